// File: rtl/fir_datapath_mc_pkg.sv
// rtl/fir_datapath_mc_pkg.sv - shared types and arithmetic helpers for the multi-channel FIR datapath
package fir_datapath_mc_package;

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Wide enough for any accumulator this block can be built with.
  localparam int MAX_ACC_W = 64;

  // Exact accumulator width: a full product plus growth for summing nb_taps terms.
  function automatic int acc_width(input int dw, input int nb_taps);
    return 2 * dw + $clog2(nb_taps);
  endfunction

  // Round half toward +inf, arithmetic shift right, then clamp to the signed dw-bit range.
  function automatic logic signed [MAX_ACC_W-1:0] round_shift_sat(
    input logic signed [MAX_ACC_W-1:0] acc,
    input int                          shift,
    input int                          dw
  );
    logic signed [MAX_ACC_W-1:0] r;
    logic signed [MAX_ACC_W-1:0] hi;
    logic signed [MAX_ACC_W-1:0] lo;
    r = acc;
    if (shift > 0) begin
      r = r + (64'sd1 <<< (shift - 1));
    end
    r  = r >>> shift;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    if (r > hi) begin
      r = hi;
    end else if (r < lo) begin
      r = lo;
    end
    return r;
  endfunction

endpackage

// File: rtl/fir_datapath_mc_lane.sv
// rtl/fir_datapath_mc_lane.sv - one channel: delay line plus multiply-accumulate over the shared coefficients
module fir_mc_lane
  import fir_datapath_mc_package::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int NB_TAPS    = 4,
  parameter int ACC_W      = acc_width(DATA_WIDTH, NB_TAPS)
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            clear_i,
  input  logic                            shift_en,
  input  logic signed [DATA_WIDTH-1:0]    sample,
  input  logic [NB_TAPS*DATA_WIDTH-1:0]   coeff,
  output logic signed [ACC_W-1:0]         acc
);

  logic signed [DATA_WIDTH-1:0] dl  [NB_TAPS-1];
  logic signed [DATA_WIDTH-1:0] win [NB_TAPS];

  // History of past samples; advances only when the sample is actually consumed.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < NB_TAPS - 1; k++) dl[k] <= '0;
    end else if (clear_i) begin
      for (int k = 0; k < NB_TAPS - 1; k++) dl[k] <= '0;
    end else if (shift_en) begin
      dl[0] <= sample;
      for (int k = 1; k < NB_TAPS - 1; k++) dl[k] <= dl[k-1];
    end
  end

  // Filter window: newest sample first so coeff[0] weights the current input.
  always_comb begin
    win[0] = sample;
    for (int k = 1; k < NB_TAPS; k++) win[k] = dl[k-1];
  end

  // Full-precision dot product of window and coefficients.
  always_comb begin
    logic signed [DATA_WIDTH-1:0]   c;
    logic signed [2*DATA_WIDTH-1:0] prod;
    acc  = '0;
    c    = '0;
    prod = '0;
    for (int k = 0; k < NB_TAPS; k++) begin
      c    = signed'(coeff[k*DATA_WIDTH +: DATA_WIDTH]);
      prod = win[k] * c;
      acc  = acc + ACC_W'(prod);
    end
  end

endmodule

// File: rtl/fir_datapath_mc.sv
// rtl/fir_datapath_mc.sv - multi-channel FIR datapath with runtime coefficient load and stream handshakes
module fir_datapath_mc
  import fir_datapath_mc_package::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int NB_TAPS     = 4,
  parameter int NB_CH       = 2,
  parameter int SHIFT_WIDTH = 5
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          clear_i,
  input  logic [SHIFT_WIDTH-1:0]        shift_i,
  input  logic [NB_CH*DATA_WIDTH-1:0]   x_data,
  input  logic                          x_valid,
  output logic                          x_ready,
  input  logic [NB_CH*DATA_WIDTH/8-1:0] x_strb,
  input  logic [DATA_WIDTH-1:0]         h_data,
  input  logic                          h_valid,
  output logic                          h_ready,
  input  logic [DATA_WIDTH/8-1:0]       h_strb,
  output logic [NB_CH*DATA_WIDTH-1:0]   y_data,
  output logic                          y_valid,
  input  logic                          y_ready,
  output logic [NB_CH*DATA_WIDTH/8-1:0] y_strb,
  output logic                          coeff_ready_o
);

  localparam int ACC_W = acc_width(DATA_WIDTH, NB_TAPS);
  localparam int CNT_W = $clog2(NB_TAPS);

  state_t                        state;
  logic [CNT_W-1:0]              cnt;
  logic [DATA_WIDTH-1:0]         coeff [NB_TAPS];
  logic [NB_TAPS*DATA_WIDTH-1:0] coeff_bus;
  logic [NB_CH*DATA_WIDTH-1:0]   y_next;
  logic                          x_hs;
  logic                          h_hs;
  logic                          y_hs;
  logic                          unused_strb;

  // Strobes carry no information for this datapath.
  assign unused_strb = ^{x_strb, h_strb};
  assign y_strb      = '1;

  // One-entry output register: accept a new sample whenever the slot is free or draining this cycle.
  assign x_ready = (state == RUN) & (~y_valid | y_ready);

  // Clear wins over any handshake in the same cycle.
  assign x_hs = x_valid & x_ready & ~clear_i;
  assign h_hs = h_valid & h_ready & ~clear_i;
  assign y_hs = y_valid & y_ready;

  // Flatten the coefficient file into the bus shared by all lanes.
  always_comb begin
    coeff_bus = '0;
    for (int k = 0; k < NB_TAPS; k++) coeff_bus[k*DATA_WIDTH +: DATA_WIDTH] = coeff[k];
  end

  // Load/run controller with coefficient file, tap counter and registered status outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state         <= LOAD;
      cnt           <= '0;
      h_ready       <= 1'b1;
      coeff_ready_o <= 1'b0;
      for (int k = 0; k < NB_TAPS; k++) coeff[k] <= '0;
    end else if (clear_i) begin
      state         <= LOAD;
      cnt           <= '0;
      h_ready       <= 1'b1;
      coeff_ready_o <= 1'b0;
      for (int k = 0; k < NB_TAPS; k++) coeff[k] <= '0;
    end else begin
      case (state)
        LOAD: begin
          if (h_hs) begin
            coeff[cnt] <= h_data;
            if (cnt == CNT_W'(NB_TAPS - 1)) begin
              cnt           <= '0;
              state         <= RUN;
              h_ready       <= 1'b0;
              coeff_ready_o <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        RUN: begin
          state <= RUN;
        end
        default: begin
          state <= LOAD;
        end
      endcase
    end
  end

  for (genvar c = 0; c < NB_CH; c++) begin : g_lane
    logic signed [ACC_W-1:0] acc;

    fir_mc_lane #(
      .DATA_WIDTH (DATA_WIDTH),
      .NB_TAPS    (NB_TAPS),
      .ACC_W      (ACC_W)
    ) u_lane (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .clear_i  (clear_i),
      .shift_en (x_hs),
      .sample   (x_data[c*DATA_WIDTH +: DATA_WIDTH]),
      .coeff    (coeff_bus),
      .acc      (acc)
    );

    assign y_next[c*DATA_WIDTH +: DATA_WIDTH] =
      DATA_WIDTH'(round_shift_sat(MAX_ACC_W'(acc), int'(shift_i), DATA_WIDTH));
  end

  // Output register: load on accept, empty on drain, hold while stalled.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      y_valid <= 1'b0;
      y_data  <= '0;
    end else if (clear_i) begin
      y_valid <= 1'b0;
      y_data  <= '0;
    end else if (x_hs) begin
      y_valid <= 1'b1;
      y_data  <= y_next;
    end else if (y_hs) begin
      y_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fir_datapath_mc.sv
// tb/tb_fir_datapath_mc.sv - directed scoreboard bench for fir_datapath_mc
module tb_fir_datapath_mc;

  localparam int DW = 16;
  localparam int NT = 4;
  localparam int NC = 2;
  localparam int SW = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic              clear;
  logic [SW-1:0]     shift;
  logic [NC*DW-1:0]  x_data;
  logic              x_valid;
  logic              x_ready;
  logic [NC*DW/8-1:0] x_strb;
  logic [DW-1:0]     h_data;
  logic              h_valid;
  logic              h_ready;
  logic [DW/8-1:0]   h_strb;
  logic [NC*DW-1:0]  y_data;
  logic              y_valid;
  logic              y_ready;
  logic [NC*DW/8-1:0] y_strb;
  logic              coeff_ready;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;
  int n_acc   = 0;
  int base;
  logic [31:0] exp_q [$];

  fir_datapath_mc #(
    .DATA_WIDTH  (DW),
    .NB_TAPS     (NT),
    .NB_CH       (NC),
    .SHIFT_WIDTH (SW)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .clear_i       (clear),
    .shift_i       (shift),
    .x_data        (x_data),
    .x_valid       (x_valid),
    .x_ready       (x_ready),
    .x_strb        (x_strb),
    .h_data        (h_data),
    .h_valid       (h_valid),
    .h_ready       (h_ready),
    .h_strb        (h_strb),
    .y_data        (y_data),
    .y_valid       (y_valid),
    .y_ready       (y_ready),
    .y_strb        (y_strb),
    .coeff_ready_o (coeff_ready)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: every output handshake must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && y_valid === 1'b1 && y_ready === 1'b1) begin
      if (exp_q.size() == 0) check("y_unexpected", {31'd0, y_valid}, 32'd0);
      else check("y_data", y_data, exp_q.pop_front());
    end
  end

  task automatic load_h(input logic [DW-1:0] v, input bit chk_x);
    bit ok;
    ok      = 1'b0;
    h_valid = 1'b1;
    h_data  = v;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (h_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("h_timeout", {31'd0, ok}, 32'd1);
    if (ok && chk_x) check("load_x_gated", {31'd0, x_ready}, 32'd0);
    @(posedge clk);
    #1;
    h_valid = 1'b0;
  endtask

  task automatic send_x(input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [DW-1:0] ea, input logic [DW-1:0] eb);
    bit ok;
    ok      = 1'b0;
    x_valid = 1'b1;
    x_data  = {b, a};
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (x_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("x_timeout", {31'd0, ok}, 32'd1);
    else exp_q.push_back({eb, ea});
    @(posedge clk);
    #1;
    x_valid = 1'b0;
    if (ok) n_acc++;
  endtask

  task automatic drain();
    for (int t = 0; t < 100 && exp_q.size() != 0; t++) @(posedge clk);
    check("drain", exp_q.size(), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    @(posedge clk);
    #1 clear = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n   = 1'b0;
    clear   = 1'b0;
    shift   = '0;
    x_data  = '0;
    x_valid = 1'b0;
    x_strb  = '0;
    h_data  = '0;
    h_valid = 1'b0;
    h_strb  = '1;
    y_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state
    @(negedge clk);
    check("rst_y_valid", {31'd0, y_valid}, 32'd0);
    check("rst_y_data", y_data, 32'd0);
    check("rst_y_strb", {28'd0, y_strb}, 32'hF);
    check("rst_h_ready", {31'd0, h_ready}, 32'd1);
    check("rst_x_ready", {31'd0, x_ready}, 32'd0);
    check("rst_coeff_ready", {31'd0, coeff_ready}, 32'd0);
    @(posedge clk);
    #1;

    // Load 1,2,3,4 while x is offered: it must never be taken during LOAD
    x_valid = 1'b1;
    x_data  = 32'h0005_0005;
    load_h(16'd1, 1'b1);
    load_h(16'd2, 1'b1);
    load_h(16'd3, 1'b1);
    load_h(16'd4, 1'b1);
    x_valid = 1'b0;
    @(negedge clk);
    check("load_no_y", {31'd0, y_valid}, 32'd0);
    check("run_coeff_ready", {31'd0, coeff_ready}, 32'd1);
    check("run_h_ready", {31'd0, h_ready}, 32'd0);
    check("run_x_ready", {31'd0, x_ready}, 32'd1);
    @(posedge clk);
    #1;

    // Impulse on lane 0, silence on lane 1
    send_x(16'd1, 16'd0, 16'd1, 16'd0);
    check("first_y_latency", {31'd0, y_valid}, 32'd1);
    send_x(16'd0, 16'd0, 16'd2, 16'd0);
    send_x(16'd0, 16'd0, 16'd3, 16'd0);
    send_x(16'd0, 16'd0, 16'd4, 16'd0);
    send_x(16'd0, 16'd0, 16'd0, 16'd0);
    drain();

    // Saturation, positive then negative
    do_clear();
    for (int i = 0; i < 4; i++) load_h(16'h7FFF, 1'b0);
    for (int i = 0; i < 4; i++) send_x(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
    send_x(16'h8000, 16'h8000, 16'h7FFF, 16'h7FFF);
    for (int i = 0; i < 3; i++) send_x(16'h8000, 16'h8000, 16'h8000, 16'h8000);
    drain();

    // Rounding half toward +inf, then a mid-stream shift change
    do_clear();
    load_h(16'd1, 1'b0);
    for (int i = 0; i < 3; i++) load_h(16'd0, 1'b0);
    shift = 5'd1;
    send_x(16'd3, 16'd5, 16'd2, 16'd3);
    send_x(16'hFFFD, 16'hFFFB, 16'hFFFF, 16'hFFFE);
    send_x(16'd2, 16'd0, 16'd1, 16'd0);
    shift = 5'd2;
    send_x(16'd7, 16'hFFF9, 16'd2, 16'hFFFE);
    drain();
    shift = 5'd0;

    // Backpressure: output stalled for several cycles under continuous input
    do_clear();
    load_h(16'd1, 1'b0);
    for (int i = 0; i < 3; i++) load_h(16'd0, 1'b0);
    y_ready = 1'b0;
    base    = n_acc;
    fork
      begin
        for (int i = 0; i < 6; i++)
          send_x(16'(10 + i), 16'(16'hFF00 + i), 16'(10 + i), 16'(16'hFF00 + i));
      end
      begin
        for (int t = 0; t < 50 && n_acc == base; t++) @(negedge clk);
        repeat (6) begin
          @(negedge clk);
          check("bp_y_valid", {31'd0, y_valid}, 32'd1);
          check("bp_x_ready", {31'd0, x_ready}, 32'd0);
          check("bp_y_hold", y_data, {16'hFF00, 16'd10});
        end
        check("bp_accepted", n_acc - base, 32'd1);
        @(posedge clk);
        #1 y_ready = 1'b1;
      end
    join
    drain();

    // Clear mid-stream with coincident x and h valid
    send_x(16'd1, 16'd2, 16'd1, 16'd2);
    send_x(16'd3, 16'd4, 16'd3, 16'd4);
    send_x(16'd5, 16'd6, 16'd5, 16'd6);
    drain();
    x_valid = 1'b1;
    x_data  = 32'h0009_0009;
    h_valid = 1'b1;
    h_data  = 16'd7;
    clear   = 1'b1;
    @(posedge clk);
    #1;
    clear   = 1'b0;
    x_valid = 1'b0;
    h_valid = 1'b0;
    check("clr_coeff_ready", {31'd0, coeff_ready}, 32'd0);
    check("clr_y_valid", {31'd0, y_valid}, 32'd0);
    check("clr_h_ready", {31'd0, h_ready}, 32'd1);
    check("clr_x_ready", {31'd0, x_ready}, 32'd0);
    load_h(16'd2, 1'b0);
    for (int i = 0; i < 3; i++) load_h(16'd0, 1'b0);
    send_x(16'd5, 16'd5, 16'd10, 16'd10);
    drain();

    // Asynchronous reset part-way through a coefficient load
    do_clear();
    load_h(16'd9, 1'b0);
    load_h(16'd9, 1'b0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_y_valid", {31'd0, y_valid}, 32'd0);
    check("mid_rst_y_data", y_data, 32'd0);
    check("mid_rst_y_strb", {28'd0, y_strb}, 32'hF);
    check("mid_rst_h_ready", {31'd0, h_ready}, 32'd1);
    check("mid_rst_x_ready", {31'd0, x_ready}, 32'd0);
    check("mid_rst_coeff_ready", {31'd0, coeff_ready}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    load_h(16'd5, 1'b0);
    load_h(16'd6, 1'b0);
    load_h(16'd7, 1'b0);
    @(negedge clk);
    check("three_h_x_ready", {31'd0, x_ready}, 32'd0);
    check("three_h_coeff_ready", {31'd0, coeff_ready}, 32'd0);
    @(posedge clk);
    #1;
    load_h(16'd8, 1'b0);
    @(negedge clk);
    check("four_h_x_ready", {31'd0, x_ready}, 32'd1);
    check("four_h_coeff_ready", {31'd0, coeff_ready}, 32'd1);
    @(posedge clk);
    #1;
    send_x(16'd1, 16'd0, 16'd5, 16'd0);
    send_x(16'd0, 16'd0, 16'd6, 16'd0);
    send_x(16'd0, 16'd1, 16'd7, 16'd5);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
